// File: rtl/alu_dispatch.sv
// rtl/alu_dispatch.sv - request sequencer that drives the alu datapath and returns its result
// Purpose: accept one op over req valid/ready, hold the ALU inputs stable for
//   ALU_LATENCY+1 cycles with the result enable raised, capture o_alu_output
//   and hand it back over rsp valid/ready.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   i_req_valid / o_req_ready       request handshake (ready only in IDLE)
//   i_req_op, i_req_a, i_req_b      op code and operands
//   i_req_addr, i_req_pc            direct address and program count
//   o_operand0/1, o_address_reg,
//   o_program_count, o_config,
//   o_alu_re_oen, o_alu_ad_oen      ALU-facing inputs
//   i_alu_output                    ALU result
//   o_rsp_valid / i_rsp_ready       response handshake
//   o_rsp_data, o_rsp_illegal       captured result, unsupported-op flag
//   o_busy                          high whenever not IDLE
module alu_dispatch #(
  parameter int unsigned           DATA_WIDTH   = 16,
  // Legal range 0..15; 0 means a combinational ALU.
  parameter int unsigned           ALU_LATENCY  = 1,
  parameter logic [DATA_WIDTH-1:0] ALU_COMPARER = DATA_WIDTH'(1),
  parameter logic [DATA_WIDTH-1:0] ALU_JUMP_CON = DATA_WIDTH'(2)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [DATA_WIDTH-1:0] i_req_op,
  input  logic [DATA_WIDTH-1:0] i_req_a,
  input  logic [DATA_WIDTH-1:0] i_req_b,
  input  logic [DATA_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_pc,
  output logic [DATA_WIDTH-1:0] o_operand0,
  output logic [DATA_WIDTH-1:0] o_operand1,
  output logic [DATA_WIDTH-1:0] o_address_reg,
  output logic [DATA_WIDTH-1:0] o_program_count,
  output logic [DATA_WIDTH-1:0] o_config,
  output logic                  o_alu_re_oen,
  output logic                  o_alu_ad_oen,
  input  logic [DATA_WIDTH-1:0] i_alu_output,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_data,
  output logic                  o_rsp_illegal,
  output logic                  o_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] op_q, op_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  illegal_q, illegal_d;
  logic                  op_supported;

  assign op_supported = (i_req_op == ALU_COMPARER) || (i_req_op == ALU_JUMP_CON);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      addr_q    <= '0;
      pc_q      <= '0;
      data_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      addr_q    <= addr_d;
      pc_q      <= pc_d;
      data_q    <= data_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    addr_d    = addr_q;
    pc_d      = pc_q;
    data_d    = data_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          op_d   = i_req_op;
          a_d    = i_req_a;
          b_d    = i_req_b;
          addr_d = i_req_addr;
          pc_d   = i_req_pc;
          if (op_supported) begin
            state_d = EXEC;
            cnt_d   = 4'(ALU_LATENCY);
          end else begin
            // Unsupported ops bypass the ALU entirely.
            state_d   = RESP;
            data_d    = '0;
            illegal_d = 1'b1;
          end
        end
      end
      EXEC: begin
        // cnt only ever counts down to zero, so it cannot wrap.
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          data_d    = i_alu_output;
          illegal_d = 1'b0;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (i_rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake and ALU control are pure decodes of the state, so ready and
  // valid can never overlap and config returns to 0 outside EXEC.
  assign o_req_ready     = (state_q == IDLE);
  assign o_busy          = (state_q != IDLE);
  assign o_rsp_valid     = (state_q == RESP);
  assign o_alu_re_oen    = (state_q == EXEC);
  assign o_alu_ad_oen    = 1'b0;
  assign o_config        = (state_q == EXEC) ? op_q : '0;
  assign o_operand0      = a_q;
  assign o_operand1      = b_q;
  assign o_address_reg   = addr_q;
  assign o_program_count = pc_q;
  assign o_rsp_data      = data_q;
  assign o_rsp_illegal   = illegal_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// tb/tb_alu_dispatch.sv - self-checking bench for alu_dispatch
module tb_alu_dispatch;

  localparam int          DW     = 16;
  localparam int          MAIN_L = 1;
  localparam logic [15:0] CMP    = 16'h0001;
  localparam logic [15:0] JMP    = 16'h0002;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- main instance (ALU_LATENCY = 1) ----------------
  logic          rst, req_valid, rsp_ready;
  logic [DW-1:0] req_op, req_a, req_b, req_addr, req_pc;
  logic          o_req_ready, o_alu_re_oen, o_alu_ad_oen, o_rsp_valid, o_rsp_illegal, o_busy;
  logic [DW-1:0] o_operand0, o_operand1, o_address_reg, o_program_count, o_config, o_rsp_data;
  logic [DW-1:0] m_pipe;

  function automatic logic [15:0] alu_f(input logic oen, input logic [15:0] cfg,
                                        input logic [15:0] x, input logic [15:0] y,
                                        input logic [15:0] adr);
    if (!oen)       return 16'h0;
    if (cfg == CMP) return x ^ y;
    if (cfg == JMP) return adr;
    return 16'h0;
  endfunction

  function automatic int lat_of(input int g);
    case (g)
      0:       return 0;
      1:       return 1;
      2:       return 3;
      default: return 15;
    endcase
  endfunction

  always @(posedge clk) m_pipe <= alu_f(o_alu_re_oen, o_config, o_operand0, o_operand1, o_address_reg);

  alu_dispatch #(
    .DATA_WIDTH(DW), .ALU_LATENCY(MAIN_L), .ALU_COMPARER(CMP), .ALU_JUMP_CON(JMP)
  ) u_dut (
    .clk(clk), .rst(rst),
    .i_req_valid(req_valid), .o_req_ready(o_req_ready),
    .i_req_op(req_op), .i_req_a(req_a), .i_req_b(req_b),
    .i_req_addr(req_addr), .i_req_pc(req_pc),
    .o_operand0(o_operand0), .o_operand1(o_operand1),
    .o_address_reg(o_address_reg), .o_program_count(o_program_count),
    .o_config(o_config), .o_alu_re_oen(o_alu_re_oen), .o_alu_ad_oen(o_alu_ad_oen),
    .i_alu_output(m_pipe),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_data(o_rsp_data), .o_rsp_illegal(o_rsp_illegal), .o_busy(o_busy)
  );

  // ---------------- latency sweep instances ----------------
  logic          sw_rst, sw_valid, sw_ready;
  logic [DW-1:0] sw_op, sw_a, sw_b, sw_addr, sw_pc;
  logic          sw_req_ready [4];
  logic          sw_oen [4];
  logic          sw_ad_oen [4];
  logic          sw_rsp_valid [4];
  logic          sw_illegal [4];
  logic          sw_busy [4];
  logic [DW-1:0] sw_o0 [4];
  logic [DW-1:0] sw_o1 [4];
  logic [DW-1:0] sw_adr [4];
  logic [DW-1:0] sw_pco [4];
  logic [DW-1:0] sw_cfg [4];
  logic [DW-1:0] sw_alu [4];
  logic [DW-1:0] sw_rsp_data [4];

  for (genvar g = 0; g < 4; g++) begin : g_sw
    localparam int L = lat_of(g);
    logic [DW-1:0] pipe [16];
    logic [DW-1:0] now_v;
    assign now_v = alu_f(sw_oen[g], sw_cfg[g], sw_o0[g], sw_o1[g], sw_adr[g]);
    always @(posedge clk) begin
      pipe[0] <= now_v;
      for (int i = 1; i < 16; i++) pipe[i] <= pipe[i-1];
    end
    assign sw_alu[g] = (L == 0) ? now_v : pipe[(L == 0) ? 0 : L - 1];

    alu_dispatch #(
      .DATA_WIDTH(DW), .ALU_LATENCY(L), .ALU_COMPARER(CMP), .ALU_JUMP_CON(JMP)
    ) u_sw (
      .clk(clk), .rst(sw_rst),
      .i_req_valid(sw_valid), .o_req_ready(sw_req_ready[g]),
      .i_req_op(sw_op), .i_req_a(sw_a), .i_req_b(sw_b),
      .i_req_addr(sw_addr), .i_req_pc(sw_pc),
      .o_operand0(sw_o0[g]), .o_operand1(sw_o1[g]),
      .o_address_reg(sw_adr[g]), .o_program_count(sw_pco[g]),
      .o_config(sw_cfg[g]), .o_alu_re_oen(sw_oen[g]), .o_alu_ad_oen(sw_ad_oen[g]),
      .i_alu_output(sw_alu[g]),
      .o_rsp_valid(sw_rsp_valid[g]), .i_rsp_ready(sw_ready),
      .o_rsp_data(sw_rsp_data[g]), .o_rsp_illegal(sw_illegal[g]), .o_busy(sw_busy[g])
    );
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_req_ready"}, o_req_ready, 1);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_rsp_valid"}, o_rsp_valid, 0);
    check({tag, "_rsp_data"}, o_rsp_data, 0);
    check({tag, "_illegal"}, o_rsp_illegal, 0);
    check({tag, "_re_oen"}, o_alu_re_oen, 0);
    check({tag, "_ad_oen"}, o_alu_ad_oen, 0);
    check({tag, "_config"}, o_config, 0);
    check({tag, "_operand0"}, o_operand0, 0);
    check({tag, "_operand1"}, o_operand1, 0);
    check({tag, "_address"}, o_address_reg, 0);
    check({tag, "_pc"}, o_program_count, 0);
  endtask

  task automatic rand_inputs();
    req_valid = 1'($urandom);
    rsp_ready = 1'($urandom);
    req_op    = 16'($urandom);
    req_a     = 16'($urandom);
    req_b     = 16'($urandom);
    req_addr  = 16'($urandom);
    req_pc    = 16'($urandom);
  endtask

  // Issues one request from IDLE with rsp_ready high and checks the whole
  // transaction against the reference: cycle of response, data, flag and
  // how many cycles the result enable was raised.
  task automatic run_op(input string tag, input logic [15:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] addr, input logic [15:0] pc);
    logic        legal;
    logic [15:0] d_exp;
    int          n;
    int          oen_n;
    legal = (op == CMP) || (op == JMP);
    d_exp = (op == CMP) ? (a ^ b) : ((op == JMP) ? addr : 16'h0);
    check({tag, "_ready_before"}, o_req_ready, 1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_addr = addr; req_pc = pc;
    rsp_ready = 1'b1;
    n = 0;
    oen_n = 0;
    do begin
      @(negedge clk);
      n++;
      req_valid = 1'b0;
      req_a     = 16'($urandom);
      req_op    = 16'($urandom);
      if (o_alu_re_oen) begin
        oen_n++;
        check({tag, "_config_exec"}, o_config, op);
      end
    end while (!o_rsp_valid && n < 40);
    check({tag, "_rsp_cycle"}, n, legal ? MAIN_L + 2 : 1);
    check({tag, "_rsp_data"}, o_rsp_data, d_exp);
    check({tag, "_illegal"}, o_rsp_illegal, !legal);
    check({tag, "_oen_cycles"}, oen_n, legal ? MAIN_L + 1 : 0);
    check({tag, "_req_ready_resp"}, o_req_ready, 0);
    check({tag, "_config_resp"}, o_config, 0);
    check({tag, "_operand0"}, o_operand0, a);
    check({tag, "_operand1"}, o_operand1, b);
    check({tag, "_address"}, o_address_reg, addr);
    check({tag, "_pc"}, o_program_count, pc);
    @(negedge clk);
    check({tag, "_ready_after"}, o_req_ready, 1);
    check({tag, "_valid_after"}, o_rsp_valid, 0);
  endtask

  logic [15:0] tab_op [64];
  logic [15:0] tab_a [64];
  logic [15:0] tab_b [64];
  logic [15:0] tab_addr [64];

  initial begin
    sw_rst = 1'b1; sw_valid = 1'b0; sw_ready = 1'b1;
    sw_op = '0; sw_a = '0; sw_b = '0; sw_addr = '0; sw_pc = '0;

    // Reset with random inputs for three cycles.
    rst = 1'b1;
    rand_inputs();
    repeat (3) begin
      @(negedge clk);
      check_idle("reset");
      rand_inputs();
    end
    rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    @(negedge clk);
    check_idle("post_reset");

    // Compare op: a^b from the ALU model.
    run_op("compare", CMP, 16'h00F0, 16'h0F00, 16'($urandom), 16'($urandom));

    // Backpressure: response held for five cycles, a request in that window is ignored.
    req_valid = 1'b1; req_op = JMP; req_a = 16'h1111; req_b = 16'h2222;
    req_addr = 16'h0040; req_pc = 16'h0123; rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", o_rsp_valid, 1);
      check("bp_rsp_data", o_rsp_data, 16'h0040);
      check("bp_illegal", o_rsp_illegal, 0);
      check("bp_req_ready", o_req_ready, 0);
      req_valid = 1'b1; req_op = CMP; req_a = 16'hAAAA; req_addr = 16'h5555;
      if (i == 4) rsp_ready = 1'b1;
      @(negedge clk);
    end
    check("bp_ready_after", o_req_ready, 1);
    check("bp_valid_after", o_rsp_valid, 0);
    check("bp_operand0_kept", o_operand0, 16'h1111);
    check("bp_address_kept", o_address_reg, 16'h0040);
    req_valid = 1'b0;
    @(negedge clk);
    check("bp_idle_busy", o_busy, 0);

    // Unsupported op.
    run_op("illegal", 16'hFFFF, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));

    // Reset during the second EXEC cycle.
    req_valid = 1'b1; req_op = CMP; req_a = 16'($urandom); req_b = 16'($urandom);
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("midrst_in_exec", o_alu_re_oen, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("midrst");
    @(negedge clk);
    check("midrst_no_rsp", o_rsp_valid, 0);
    run_op("after_rst", CMP, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));

    // Random ops, including unsupported codes.
    for (int k = 0; k < 8; k++) begin
      logic [15:0] op;
      case ($urandom_range(0, 2))
        0:       op = CMP;
        1:       op = JMP;
        default: op = 16'h8000 | 16'($urandom);
      endcase
      run_op($sformatf("rand%0d", k), op, 16'($urandom), 16'($urandom),
             16'($urandom), 16'($urandom));
    end

    // Latency sweep: back-to-back requests, rsp_ready tied high.
    sw_rst = 1'b0; sw_valid = 1'b1;
    for (int t = 0; t < 64; t++) begin
      for (int g = 0; g < 4; g++) begin
        int   lt;
        logic ev;
        int   s;
        lt = lat_of(g);
        ev = (t >= lt + 2) && (((t - lt - 2) % (lt + 3)) == 0);
        check($sformatf("sw_l%0d_valid_t%0d", lt, t), sw_rsp_valid[g], ev);
        check($sformatf("sw_l%0d_ready_t%0d", lt, t), sw_req_ready[g], (t % (lt + 3)) == 0);
        if (ev) begin
          s = t - lt - 2;
          check($sformatf("sw_l%0d_data_t%0d", lt, t), sw_rsp_data[g],
                (tab_op[s] == CMP) ? (tab_a[s] ^ tab_b[s]) : tab_addr[s]);
          check($sformatf("sw_l%0d_illegal_t%0d", lt, t), sw_illegal[g], 0);
        end
      end
      tab_op[t]   = $urandom_range(0, 1) ? CMP : JMP;
      tab_a[t]    = 16'($urandom);
      tab_b[t]    = 16'($urandom);
      tab_addr[t] = 16'($urandom);
      sw_op = tab_op[t]; sw_a = tab_a[t]; sw_b = tab_b[t]; sw_addr = tab_addr[t];
      sw_pc = 16'($urandom);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_dispatch.md
# alu_dispatch

Sequencing front-end for the `alu` datapath: accepts one operation request over a valid/ready handshake and drives the ALU's operand, config and output-enable inputs for the required number of cycles. It captures the ALU's `o_alu_output` and returns it to the requester over a second valid/ready handshake. It sits between the core's decode/control stage and the `alu` instance, so the control logic never has to time the ALU directly.

## Interface
- `DATA_WIDTH`, default `DATA_WIDTH` from define.v: width of operands, addresses, config and result.
- `ALU_LATENCY`, default 1: clock edges from stable ALU inputs to valid `o_alu_output`. Legal range 0..15; 0 means a combinational ALU.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `i_req_valid`  in  1  request valid.
- `o_req_ready`  out  1  request ready; high only in IDLE.
- `i_req_op`  in  DATA_WIDTH  operation code, `ALU_COMPARER` or `ALU_JUMP_CON`.
- `i_req_a`, `i_req_b`  in  DATA_WIDTH  operands 0 and 1.
- `i_req_addr`, `i_req_pc`  in  DATA_WIDTH  direct address and program count.
- `o_operand0`, `o_operand1`, `o_address_reg`, `o_program_count`  out  DATA_WIDTH  to ALU.
- `o_config`  out  DATA_WIDTH  to ALU `i_config`.
- `o_alu_re_oen`  out  1  to ALU result output enable.
- `o_alu_ad_oen`  out  1  to ALU; tied 0.
- `i_alu_output`  in  DATA_WIDTH  from ALU `o_alu_output`.
- `o_rsp_valid`  out  1  response valid.
- `i_rsp_ready`  in  1  response ready.
- `o_rsp_data`  out  DATA_WIDTH  captured result.
- `o_rsp_illegal`  out  1  the op was not a supported code.
- `o_busy`  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - `o_req_ready`=1.
  - On `i_req_valid`: register op, a, b, addr and pc.
  - Supported op: go to EXEC with `cnt`=ALU_LATENCY.
  - Unsupported op: go to RESP with `o_rsp_data`=0 and `o_rsp_illegal`=1. EXEC is skipped and `o_alu_re_oen` is never asserted.
- **EXEC**
  - `o_alu_re_oen`=1 and `o_config`=registered op.
  - If `cnt`≠0, decrement `cnt`.
  - If `cnt`==0, capture `i_alu_output` into `o_rsp_data`, set `o_rsp_illegal`=0 and go to RESP.
- **RESP**
  - `o_rsp_valid`=1.
  - `o_rsp_data` and `o_rsp_illegal` are held stable until `i_rsp_ready`.
  - On `i_rsp_ready`, go to IDLE.
- ALU inputs:
  - Operand, address and program-count outputs hold the last accepted request's values until the next accept.
  - They load only on accept and never glitch mid-operation.
  - `o_config`=0 in IDLE and RESP, so the ALU default branch drives 0.
- Requests are not queued. `i_req_valid` in EXEC or RESP is ignored until IDLE.
- `cnt` is 4 bits wide and never wraps. It only counts down from ALU_LATENCY to 0.

## Timing
- Reset: all of these go to 0: state=IDLE, `o_rsp_valid`, `o_rsp_data`, `o_rsp_illegal`, `o_alu_re_oen`, `o_config`, `o_busy`, `cnt`, and all operand, address and program-count outputs.
  - `o_req_ready`=1 from the first cycle after reset.
- Reset mid-operation (EXEC or RESP): the in-flight result is discarded. The next cycle is IDLE with the reset values above, and no response is issued.
- Cycle numbering for a supported op, accepted at the edge ending cycle 0:
  - EXEC occupies cycles 1..1+ALU_LATENCY.
  - Capture happens at the edge ending cycle 1+ALU_LATENCY.
  - `o_rsp_valid` rises in cycle 2+ALU_LATENCY.
- Unsupported op: `o_rsp_valid` rises in cycle 1.
- If `i_rsp_ready` is already high, RESP lasts one cycle and `o_req_ready` is back to 1 the following cycle.
- Best-case throughput: one op per ALU_LATENCY+3 cycles.
- `i_rsp_ready` low stalls RESP indefinitely with outputs stable.
- `i_req_valid` and `i_rsp_ready` arriving in the same cycle in RESP: the response completes and the request is not accepted until IDLE.
- `o_req_ready` and `o_rsp_valid` are never high in the same cycle.

## Test plan
- **Reset:** hold `rst`=1 for 3 cycles with random inputs -> every output is 0 except `o_req_ready`=1.
- **Compare:** ALU model with ALU_LATENCY=1 returning a^b; request `ALU_COMPARER`, a=0x00F0, b=0x0F00 ->
  - `o_alu_re_oen` high in cycles 1–2;
  - `o_rsp_valid` in cycle 3 with `o_rsp_data`=0x0FF0 and `o_rsp_illegal`=0.
- **Backpressure:** request `ALU_JUMP_CON` with addr=0x0040; model returns addr; hold `i_rsp_ready`=0 for 5 cycles ->
  - `o_rsp_data`=0x0040 held stable;
  - `o_req_ready`=0 throughout, and a new `i_req_valid` in that window is ignored.
- **Illegal op:** op=0xFFFF -> `o_rsp_valid` in cycle 1 with `o_rsp_data`=0 and `o_rsp_illegal`=1; `o_alu_re_oen` never asserted.
- **Reset mid-op:** assert `rst` in cycle 2 of EXEC -> no `o_rsp_valid`, IDLE next cycle; a following request completes normally.
- **Latency sweep:** ALU_LATENCY = 0, 1, 3, 15 with back-to-back requests and `i_rsp_ready`=1 -> responses arrive exactly ALU_LATENCY+3 cycles apart with correct data.
